trace_filter_multi: RTL and testbench
=====================================

// Module: trace_filter_multi
// PURPOSE
//  Multi-lane, runtime-configurable successor of the single-lane trace filter. Sits between the CPU
//  retire/trace interface and the trace packetiser.
//  - Marks each retired instruction keep (drop_instr=0) or drop, based on an enable mask of
//    control-flow event classes and a programmable resync timer.
//  - Adds a bypass mode and a saturating kept-instruction counter.
// PARAMETERS
//  NUM_LANES          2   instructions retired per cycle; lane 0 is oldest in program order
//  INSTR_WIDTH        32  width of one instruction word (RISC_V_INSTRUCTION_WIDTH)
//  RESYNC_TIMER_WIDTH 16  width of resync timer and resync_period
//  KEPT_CNT_WIDTH     32  width of kept_count
// PORTS
//  clk            in   1                      clock
//  rst_n          in   1                      asynchronous active-low reset
//  instr_valid    in   NUM_LANES              lane i carries a retired instruction
//  instr          in   NUM_LANES*INSTR_WIDTH  lane i = instr[i*INSTR_WIDTH +: INSTR_WIDTH]
//  filter_en      in   1                      0: bypass, every valid lane kept
//  event_en       in   8                      per-class enable, bit map below
//  resync_period  in   RESYNC_TIMER_WIDTH     timer terminal count; 0 disables timer events
//  cnt_clear      in   1                      synchronous clear of kept_count
//  drop_instr     out  NUM_LANES              1 = drop lane i (registered)
//  out_valid      out  NUM_LANES              instr_valid delayed to align with drop_instr
//  kept_count     out  KEPT_CNT_WIDTH         saturating count of kept valid instructions
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - All pipeline regs, timer and kept_count = 0; drop_instr = all 1s; out_valid = 0.
//  Event classes (event_en bit map), decoded with package constants
//   - 0 branch: [6:0]==BRANCH_OPCODE
//   - 1 jal:    [6:0]==JAL_OPCODE
//   - 2 jalr:   [6:0]==JALR_OPCODE
//   - 3 c.branch: [1:0]==C_BRANCH_OPCODE && [15:14]==C_BRANCH_FUNCT3_2_MSB
//   - 4 c.jal:    [1:0]==C_JAL_OPCODE    && [15:13]==C_JAL_FUNCT3_3_MSB
//   - 5 c.jalr:   [1:0]==C_JALR_OPCODE   && [15:13]==C_JALR_FUNCT4_3_MSB
//   - 6 wfi:      full word == WFI_INSTRUCTION
//   - 7 timer event
//  Pipeline (latency 2 cycles: input at edge N -> drop_instr/out_valid after edge N+2)
//   - S1: per lane, register valid and hit_i = valid_i & |(class_vec_i & event_en[6:0]);
//     also register tmr_hit = (timer==resync_period) & (resync_period!=0) & event_en[7].
//   - S2: keep_i = ~filter_en | hit_i | (tmr_hit & i==lowest valid S1 lane);
//     drop_instr[i] <= ~(keep_i & valid_i); out_valid <= S1 valid.
//   - Invalid lanes are always dropped, even in bypass.
//   - filter_en and event_en are sampled at S1/S2 as stated, with no extra staging.
//  Resync timer
//   - Clears to 0 when any S1 lane hit or tmr_hit is set; otherwise increments by 1 each clock.
//   - Wraps modulo 2^RESYNC_TIMER_WIDTH.
//   - resync_period changed below the current timer value: no event until after the wrap.
//   - tmr_hit with no valid S1 lane: the pending timer keep is held (sticky flag) and applied to
//     the next lowest valid lane. Flag clears when consumed or when a lane hit occurs.
//  kept_count
//   - Adds popcount(~drop_instr & out_valid) each cycle; saturates at all 1s.
//   - cnt_clear has priority: cleared that cycle and that cycle's keeps are not added.
//  Reset mid-stream
//   - In-flight S1/S2 contents are discarded; no keep is emitted for them.
// TESTING
//  - Reset: hold rst_n=0 with valid traffic -> drop_instr=11, out_valid=00, kept_count=0.
//  - Branch: event_en=8'h7F, filter_en=1, lane0=0x00B50463 (beq), lane1=0x00000013 (nop)
//    -> 2 cycles later drop_instr=10, kept_count+1.
//  - Mask: same beq with event_en[0]=0 -> drop_instr=11; timer not cleared.
//  - Timer: resync_period=5, event_en=8'h80, constant nop both lanes
//    -> lane0 kept every 6th cycle; kept_count=3 after 18 valid cycles past the first.
//  - Sticky timer: timer hit while instr_valid=00, then valid=10 -> that lane0 kept.
//  - Bypass and saturation: filter_en=0, KEPT_CNT_WIDTH=4 -> all valid kept, count stops at 15;
//    cnt_clear -> 0.

Source files
------------

// File: rtl/trace_filter_multi.sv
// trace_filter_multi: per-lane keep/drop marking of retired instructions
// ahead of the trace packetiser, with event mask, resync timer and counter.
package trace_filter_pkg;
  localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE = 7'b1100111;
  localparam logic [1:0] C_BRANCH_OPCODE = 2'b01;
  localparam logic [1:0] C_BRANCH_FUNCT3_2_MSB = 2'b11;
  localparam logic [1:0] C_JAL_OPCODE = 2'b01;
  localparam logic [2:0] C_JAL_FUNCT3_3_MSB = 3'b001;
  localparam logic [1:0] C_JALR_OPCODE = 2'b10;
  localparam logic [2:0] C_JALR_FUNCT4_3_MSB = 3'b100;
  localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;
endpackage

module trace_filter_multi #(
  parameter int NUM_LANES = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int RESYNC_TIMER_WIDTH = 16,
  parameter int KEPT_CNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_LANES-1:0]             instr_valid,
  input  logic [NUM_LANES*INSTR_WIDTH-1:0] instr,
  input  logic                             filter_en,
  input  logic [7:0]                       event_en,
  input  logic [RESYNC_TIMER_WIDTH-1:0]    resync_period,
  input  logic                             cnt_clear,
  output logic [NUM_LANES-1:0]             drop_instr,
  output logic [NUM_LANES-1:0]             out_valid,
  output logic [KEPT_CNT_WIDTH-1:0]        kept_count
);
  import trace_filter_pkg::*;

  localparam int CW = KEPT_CNT_WIDTH + 1;

  function automatic logic [6:0] classes(input logic [31:0] w);
    logic [6:0] c;
    c    = '0;
    c[0] = w[6:0] == BRANCH_OPCODE;
    c[1] = w[6:0] == JAL_OPCODE;
    c[2] = w[6:0] == JALR_OPCODE;
    c[3] = (w[1:0] == C_BRANCH_OPCODE) &&
           (w[15:14] == C_BRANCH_FUNCT3_2_MSB);
    c[4] = (w[1:0] == C_JAL_OPCODE) &&
           (w[15:13] == C_JAL_FUNCT3_3_MSB);
    c[5] = (w[1:0] == C_JALR_OPCODE) &&
           (w[15:13] == C_JALR_FUNCT4_3_MSB);
    c[6] = w == WFI_INSTRUCTION;
    return c;
  endfunction

  logic [NUM_LANES-1:0] hit_d;
  logic [NUM_LANES-1:0] s1_valid;
  logic [NUM_LANES-1:0] s1_hit;
  logic [NUM_LANES-1:0] low_lane;
  logic [NUM_LANES-1:0] keep;
  logic                 tmr_d;
  logic                 s1_tmr;
  logic                 tmr_pend;
  logic                 tmr_eff;
  logic [RESYNC_TIMER_WIDTH-1:0] timer;
  logic [CW-1:0]        kept_add;
  logic [CW-1:0]        cnt_sum;

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_d[i] = instr_valid[i] &&
        |(classes(instr[i*INSTR_WIDTH +: 32]) & event_en[6:0]);
    end
    tmr_d = (timer == resync_period) &&
            (resync_period != '0) && event_en[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= '0;
      s1_hit   <= '0;
      s1_tmr   <= 1'b0;
      timer    <= '0;
    end else begin
      s1_valid <= instr_valid;
      s1_hit   <= hit_d;
      s1_tmr   <= tmr_d;
      timer    <= (|hit_d || tmr_d) ? '0
                : timer + RESYNC_TIMER_WIDTH'(1);
    end
  end

  // A timer keep lands on the oldest valid lane; with none it waits.
  always_comb begin
    tmr_eff  = s1_tmr | tmr_pend;
    low_lane = s1_valid & (~s1_valid + NUM_LANES'(1));
    keep     = {NUM_LANES{~filter_en}} | s1_hit |
               (tmr_eff ? low_lane : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_instr <= '1;
      out_valid  <= '0;
      tmr_pend   <= 1'b0;
    end else begin
      drop_instr <= ~(keep & s1_valid);
      out_valid  <= s1_valid;
      tmr_pend   <= tmr_eff & ~|s1_valid;
    end
  end

  always_comb begin
    kept_add = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      kept_add = kept_add + CW'(out_valid[i] & ~drop_instr[i]);
    end
    cnt_sum = {1'b0, kept_count} + kept_add;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_count <= '0;
    end else if (cnt_clear) begin
      kept_count <= '0;
    end else if (cnt_sum[KEPT_CNT_WIDTH]) begin
      kept_count <= '1;
    end else begin
      kept_count <= cnt_sum[KEPT_CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_trace_filter_multi.sv
// tb_trace_filter_multi: directed and random traffic against a
// cycle-level reference of the trace filter keep/drop rules.
module tb_trace_filter_multi;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  instr_valid;
  logic [63:0] instr;
  logic        filter_en;
  logic [7:0]  event_en;
  logic [15:0] resync_period;
  logic        cnt_clear;
  logic [1:0]  drop, ov, drop4, ov4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] v;
    logic [1:0] hit;
    logic       tmr;
  } rec_t;

  rec_t       m_s1;
  bit         m_pend;
  int         m_timer;
  logic [1:0] m_drop, m_ov;
  longint     m_cnt, m_cnt4;

  trace_filter_multi dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .instr(instr), .filter_en(filter_en), .event_en(event_en),
    .resync_period(resync_period), .cnt_clear(cnt_clear),
    .drop_instr(drop), .out_valid(ov), .kept_count(cnt)
  );

  trace_filter_multi #(.KEPT_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .instr(instr), .filter_en(filter_en), .event_en(event_en),
    .resync_period(resync_period), .cnt_clear(cnt_clear),
    .drop_instr(drop4), .out_valid(ov4), .kept_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] cls(logic [31:0] w);
    logic [6:0] c = '0;
    case (w[6:0])
      7'h63: c[0] = 1'b1;
      7'h6F: c[1] = 1'b1;
      7'h67: c[2] = 1'b1;
      default: ;
    endcase
    if (w[1:0] == 2'b01 && w[15:13] inside {3'b110, 3'b111}) c[3] = 1'b1;
    if (w[1:0] == 2'b01 && w[15:13] == 3'b001) c[4] = 1'b1;
    if (w[1:0] == 2'b10 && w[15:13] == 3'b100) c[5] = 1'b1;
    if (w == 32'h1050_0073) c[6] = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = 7'h63;
      1: w[6:0] = 7'h6F;
      2: w[6:0] = 7'h67;
      3: begin w[1:0] = 2'b01; w[15:14] = 2'b11; end
      4: begin w[1:0] = 2'b01; w[15:13] = 3'b001; end
      5: begin w[1:0] = 2'b10; w[15:13] = 3'b100; end
      6: w = 32'h1050_0073;
      7: w = 32'h0000_0013;
      default: ;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_s1    = '0;
    m_pend  = 1'b0;
    m_timer = 0;
    m_drop  = 2'b11;
    m_ov    = 2'b00;
    m_cnt   = 0;
    m_cnt4  = 0;
  endtask

  task automatic model_step();
    rec_t       o;
    logic [1:0] k;
    bit         t;
    int         pc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pc = $countones(m_ov & ~m_drop);
    if (cnt_clear) begin
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin
      m_cnt  = (m_cnt + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + pc;
      m_cnt4 = (m_cnt4 + pc > 15) ? 15 : m_cnt4 + pc;
    end
    o = m_s1;
    t = o.tmr || m_pend;
    k = filter_en ? o.hit : 2'b11;
    if (t) begin
      if (o.v[0]) k[0] = 1'b1;
      else if (o.v[1]) k[1] = 1'b1;
    end
    m_pend = t && (o.v == 2'b00);
    m_drop = ~(k & o.v);
    m_ov   = o.v;
    for (int i = 0; i < 2; i++)
      m_s1.hit[i] = instr_valid[i] &&
                    ((cls(instr[i*32 +: 32]) & event_en[6:0]) != 0);
    m_s1.v   = instr_valid;
    m_s1.tmr = resync_period != 0 && event_en[7] &&
               m_timer == int'(resync_period);
    if (m_s1.hit != 0 || m_s1.tmr) m_timer = 0;
    else m_timer = (m_timer + 1) % 65536;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("drop", {62'd0, drop}, {62'd0, m_drop});
    chk("out_valid", {62'd0, ov}, {62'd0, m_ov});
    chk("kept_count", {32'd0, cnt}, m_cnt);
    chk("kept_count4", {60'd0, cnt4}, m_cnt4);
    chk("drop4", {62'd0, drop4}, {62'd0, m_drop});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    filter_en     = 1'b1;
    event_en      = 8'h7F;
    resync_period = 16'd0;
    cnt_clear     = 1'b0;
    instr_valid   = 2'b11;
    instr         = {32'h0000_0013, 32'h00B5_0463};
    model_reset();
    repeat (3) cycle();
    chk("rst_drop", {62'd0, drop}, 64'd3);
    chk("rst_ov", {62'd0, ov}, 64'd0);
    chk("rst_cnt", {32'd0, cnt}, 64'd0);
    rst_n = 1'b1;

    // beq on lane 0 kept, nop on lane 1 dropped
    cycle();
    instr_valid = 2'b00;
    cycle();
    chk("beq_drop", {62'd0, drop}, 64'd2);
    cycle();
    chk("beq_cnt", {32'd0, cnt}, 64'd1);

    event_en    = 8'h7E;
    instr_valid = 2'b11;
    cycle();
    instr_valid = 2'b00;
    cycle();
    chk("mask_drop", {62'd0, drop}, 64'd3);
    cycle();

    // periodic resync with constant nops
    do_reset();
    event_en      = 8'h80;
    resync_period = 16'd5;
    instr         = {32'h0000_0013, 32'h0000_0013};
    instr_valid   = 2'b11;
    repeat (20) cycle();
    chk("tmr_cnt", {32'd0, cnt}, 64'd3);

    // timer fires with no valid lane, then applies to lane 0
    do_reset();
    resync_period = 16'd3;
    instr_valid   = 2'b00;
    repeat (5) cycle();
    instr_valid = 2'b01;
    cycle();
    instr_valid = 2'b00;
    cycle();
    chk("sticky_drop", {62'd0, drop}, 64'd2);

    filter_en     = 1'b0;
    event_en      = 8'h00;
    resync_period = 16'd0;
    instr_valid   = 2'b11;
    repeat (10) begin
      instr = {rnd_instr(), rnd_instr()};
      cycle();
    end
    chk("byp_drop", {62'd0, drop}, 64'd0);
    chk("sat_cnt4", {60'd0, cnt4}, 64'd15);
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    chk("clr_cnt", {32'd0, cnt}, 64'd0);
    chk("clr_cnt4", {60'd0, cnt4}, 64'd0);
    instr_valid = 2'b01;
    cycle();
    cycle();
    chk("byp_inv", {62'd0, drop}, 64'd2);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      instr_valid = 2'($urandom);
      instr       = {rnd_instr(), rnd_instr()};
      filter_en   = $urandom_range(0, 7) != 0;
      cnt_clear   = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 15) == 0) event_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0)
        resync_period = 16'($urandom_range(0, 9));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
